// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one decoded op, drives the selected functional
// unit, sequences mul/div through start/done, and returns the result on a writeback port.
module alu_issue_ctrl #(
   parameter int N        = 16,
   parameter int SEL_LINE = 4,
   parameter int TIMEOUT  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [SEL_LINE-1:0] op_opcode,
   input  logic [N-1:0]        rs1_reg_val,
   input  logic [N-1:0]        rs2_reg_val,
   input  logic [3:0]          rd_addr,
   output logic [6:0]          unit_sel,
   output logic [N-1:0]        unit_rs1,
   output logic [N-1:0]        unit_rs2,
   output logic                unit_start,
   input  logic [N-1:0]        unit_result,
   input  logic                unit_done,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [3:0]          wb_rd,
   output logic [N-1:0]        wb_data,
   output logic                err_illegal,
   output logic                err_timeout,
   output logic [2:0]          dbg_state
);

   // Handshakes: an op transfers on a rising edge where op_valid && op_ready; a result
   // transfers where wb_valid && wb_ready. wb_valid/wb_rd/wb_data hold until accepted.

   localparam int NUM_UNITS = 7;
   localparam int CNT_W     = $clog2(TIMEOUT + 1);

   localparam logic [SEL_LINE-1:0] OP_MUL  = SEL_LINE'(2);
   localparam logic [SEL_LINE-1:0] OP_DIV  = SEL_LINE'(3);
   localparam logic [SEL_LINE-1:0] OP_LAST = SEL_LINE'(NUM_UNITS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXEC     = 3'd1,
      S_MC_START = 3'd2,
      S_MC_WAIT  = 3'd3,
      S_WB       = 3'd4,
      S_ERR      = 3'd5
   } state_t;

   state_t              state_q, state_d;
   state_t              idle_next;
   logic [SEL_LINE-1:0] opcode_q, opcode_d;
   logic [N-1:0]        unit_rs1_q, unit_rs1_d;
   logic [N-1:0]        unit_rs2_q, unit_rs2_d;
   logic [3:0]          wb_rd_q, wb_rd_d;
   logic [N-1:0]        wb_data_q, wb_data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_timeout_q, err_timeout_d;
   logic                div_by_zero;
   logic                cnt_at_limit;
   logic [6:0]          sel_onehot;

   // Divide by zero never reaches the divider; it writes back all ones directly.
   assign div_by_zero  = (op_opcode == OP_DIV) && (rs2_reg_val == '0);
   assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      idle_next = S_EXEC;
      if (op_opcode > OP_LAST) begin
         idle_next = S_ERR;
      end else if (op_opcode == OP_MUL) begin
         idle_next = S_MC_START;
      end else if (op_opcode == OP_DIV) begin
         idle_next = div_by_zero ? S_WB : S_MC_START;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               state_d = idle_next;
            end
         end
         S_EXEC:     state_d = S_WB;
         S_MC_START: state_d = S_MC_WAIT;
         S_MC_WAIT: begin
            if (unit_done) begin
               state_d = S_WB;
            end else if (cnt_at_limit) begin
               state_d = S_IDLE;
            end
         end
         S_WB: begin
            if (wb_ready) begin
               state_d = S_IDLE;
            end
         end
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Captured operands, result register, wait counter and timeout pulse.
   always_comb begin
      opcode_d      = opcode_q;
      unit_rs1_d    = unit_rs1_q;
      unit_rs2_d    = unit_rs2_q;
      wb_rd_d       = wb_rd_q;
      wb_data_d     = wb_data_q;
      cnt_d         = cnt_q;
      err_timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               opcode_d   = op_opcode;
               unit_rs1_d = rs1_reg_val;
               unit_rs2_d = rs2_reg_val;
               wb_rd_d    = rd_addr;
               if (div_by_zero) begin
                  wb_data_d = '1;
               end
            end
         end
         S_EXEC: begin
            wb_data_d = unit_result;
         end
         S_MC_START: begin
            cnt_d = '0;
         end
         S_MC_WAIT: begin
            // A done arriving on the final count still completes normally.
            if (unit_done) begin
               wb_data_d = unit_result;
            end else if (cnt_at_limit) begin
               err_timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opcode_q      <= '0;
         unit_rs1_q    <= '0;
         unit_rs2_q    <= '0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         cnt_q         <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         opcode_q      <= opcode_d;
         unit_rs1_q    <= unit_rs1_d;
         unit_rs2_q    <= unit_rs2_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         cnt_q         <= cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         sel_onehot[i] = (opcode_q == SEL_LINE'(i));
      end
   end

   // Output logic
   always_comb begin
      op_ready    = (state_q == S_IDLE) && !rst;
      unit_sel    = '0;
      unit_start  = 1'b0;
      wb_valid    = 1'b0;
      err_illegal = 1'b0;
      case (state_q)
         S_EXEC:    unit_sel = sel_onehot;
         S_MC_START: begin
            unit_sel   = sel_onehot;
            unit_start = 1'b1;
         end
         S_MC_WAIT: unit_sel = sel_onehot;
         S_WB:      wb_valid = 1'b1;
         S_ERR:     err_illegal = 1'b1;
         default: ;
      endcase
   end

   assign unit_rs1    = unit_rs1_q;
   assign unit_rs2    = unit_rs2_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign err_timeout = err_timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: per-transaction expected output traces feed a
// per-cycle scoreboard, and literal latency/data checks pin that model.
module tb_alu_issue_ctrl;

   localparam int N        = 16;
   localparam int SEL_LINE = 4;
   localparam int TIMEOUT  = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                op_valid;
   logic                op_ready;
   logic [SEL_LINE-1:0] op_opcode;
   logic [N-1:0]        rs1_reg_val;
   logic [N-1:0]        rs2_reg_val;
   logic [3:0]          rd_addr;
   logic [6:0]          unit_sel;
   logic [N-1:0]        unit_rs1;
   logic [N-1:0]        unit_rs2;
   logic                unit_start;
   logic [N-1:0]        unit_result;
   logic                unit_done;
   logic                wb_valid;
   logic                wb_ready;
   logic [3:0]          wb_rd;
   logic [N-1:0]        wb_data;
   logic                err_illegal;
   logic                err_timeout;
   logic [2:0]          dbg_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   alu_issue_ctrl #(.N(N), .SEL_LINE(SEL_LINE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
      .op_opcode(op_opcode), .rs1_reg_val(rs1_reg_val), .rs2_reg_val(rs2_reg_val),
      .rd_addr(rd_addr), .unit_sel(unit_sel), .unit_rs1(unit_rs1), .unit_rs2(unit_rs2),
      .unit_start(unit_start), .unit_result(unit_result), .unit_done(unit_done),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .err_illegal(err_illegal), .err_timeout(err_timeout), .dbg_state(dbg_state)
   );

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        ready;
      logic [6:0]  sel;
      logic        start;
      logic        wbv;
      logic        erri;
      logic        errt;
      logic        chk_unit;
      logic [15:0] rs1;
      logic [15:0] rs2;
      logic        chk_wb;
      logic [3:0]  rd;
      logic [15:0] data;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);

   logic [EXP_W-1:0] exp_q[$];
   int  checks = 0;
   int  errors = 0;
   bit  m_errt = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (op_ready !== e.ready || unit_sel !== e.sel || unit_start !== e.start ||
             wb_valid !== e.wbv || err_illegal !== e.erri || err_timeout !== e.errt ||
             (e.chk_unit && (unit_rs1 !== e.rs1 || unit_rs2 !== e.rs2)) ||
             (e.chk_wb && (wb_rd !== e.rd || wb_data !== e.data))) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t got rdy=%b sel=%b st=%b wbv=%b ei=%b et=%b rs1=%h rs2=%h rd=%h data=%h | expected rdy=%b sel=%b st=%b wbv=%b ei=%b et=%b rs1=%h rs2=%h rd=%h data=%h",
                     $time, op_ready, unit_sel, unit_start, wb_valid, err_illegal, err_timeout,
                     unit_rs1, unit_rs2, wb_rd, wb_data, e.ready, e.sel, e.start, e.wbv, e.erri,
                     e.errt, e.rs1, e.rs2, e.rd, e.data);
         end
      end
   end

   // ---------------- monitor for literal checks ----------------
   int cyc_n = 0, acc_cyc = 0;
   int wb_lat = -1, errt_lat = -1, rdy_lat = -1;
   int start_cnt = 0, erri_cnt = 0, errt_cnt = 0, wbv_cnt = 0, sel_cnt = 0;
   logic [15:0] wb_data_seen = '0;
   logic [3:0]  wb_rd_seen = '0;

   always @(negedge clk) begin
      cyc_n++;
      if (op_valid && op_ready) begin
         acc_cyc  = cyc_n;
         wb_lat   = -1;
         errt_lat = -1;
         rdy_lat  = -1;
      end
      if (wb_valid && wb_lat < 0) begin
         wb_lat       = cyc_n - acc_cyc;
         wb_data_seen = wb_data;
         wb_rd_seen   = wb_rd;
      end
      if (err_timeout && errt_lat < 0) errt_lat = cyc_n - acc_cyc;
      if (op_ready && rdy_lat < 0 && cyc_n > acc_cyc) rdy_lat = cyc_n - acc_cyc;
      if (unit_start) start_cnt++;
      if (err_illegal) erri_cnt++;
      if (err_timeout) errt_cnt++;
      if (wb_valid) wbv_cnt++;
      if (unit_sel != 7'd0) sel_cnt++;
   end

   int b_start, b_erri, b_errt, b_wbv, b_sel;

   task automatic snap();
      b_start = start_cnt; b_erri = erri_cnt; b_errt = errt_cnt;
      b_wbv = wbv_cnt; b_sel = sel_cnt;
   endtask

   task automatic check_lit(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [3:0] opc, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] rd, input logic done,
                        input logic [15:0] res, input logic wbr, input exp_t e);
      op_valid = v; op_opcode = opc; rs1_reg_val = a; rs2_reg_val = b; rd_addr = rd;
      unit_done = done; unit_result = res; wb_ready = wbr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // A non-accept cycle: operand inputs carry junk that must not be sampled.
   task automatic busy(input logic done, input logic [15:0] res, input logic wbr, input exp_t e);
      drive(1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), done, res, wbr, e);
   endtask

   task automatic take_idle(output exp_t e);
      e = '0;
      e.ready = 1'b1;
      e.errt = m_errt;
      m_errt = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         take_idle(e);
         busy(1'b0, 16'($urandom), 1'($urandom_range(0, 1)), e);
      end
   endtask

   // Builds the expected trace of one operation from the issue rules while driving it.
   // done_at: index of the MC_WAIT cycle raising unit_done (>= TIMEOUT means never).
   task automatic run_op(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] rd, input logic [15:0] res, input int done_at,
                         input int stall, input bit poke_done);
      exp_t e;
      logic [6:0] sel;
      logic [15:0] wbd;
      bit finished;
      sel = (opc < 4'd7) ? (7'd1 << opc) : 7'd0;
      take_idle(e);
      drive(1'b1, opc, a, b, rd, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)), e);
      if (opc > 4'd6) begin
         e = '0;
         e.erri = 1'b1;
         busy(1'b0, 16'($urandom), 1'b1, e);
         return;
      end
      if (opc == 4'd3 && b == 16'd0) begin
         wbd = 16'hFFFF;
      end else if (opc == 4'd2 || opc == 4'd3) begin
         e = '0; e.sel = sel; e.start = 1'b1; e.chk_unit = 1'b1; e.rs1 = a; e.rs2 = b;
         busy(poke_done, 16'($urandom), 1'b1, e);
         e.start = 1'b0;
         finished = 1'b0;
         for (int i = 0; i < TIMEOUT && !finished; i++) begin
            if (i == done_at) begin
               busy(1'b1, res, 1'b1, e);
               finished = 1'b1;
            end else begin
               busy(1'b0, 16'($urandom), 1'b1, e);
            end
         end
         if (!finished) begin
            m_errt = 1'b1;
            return;
         end
         wbd = res;
      end else begin
         e = '0; e.sel = sel; e.chk_unit = 1'b1; e.rs1 = a; e.rs2 = b;
         busy(poke_done, res, 1'b1, e);
         wbd = res;
      end
      for (int s = 0; s <= stall; s++) begin
         e = '0; e.wbv = 1'b1; e.chk_wb = 1'b1; e.rd = rd; e.data = wbd;
         busy(1'b0, 16'($urandom), (s == stall), e);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      exp_t e;
      logic [3:0]  q_op [4] = '{4'd1, 4'd4, 4'd5, 4'd6};
      logic [15:0] q_a  [4] = '{16'h0010, 16'hF0F0, 16'hF000, 16'hAAAA};
      logic [15:0] q_b  [4] = '{16'h0003, 16'h0FF0, 16'h000F, 16'hFFFF};
      logic [15:0] r;

      rst = 1'b1; op_valid = 1'b0; op_opcode = '0; rs1_reg_val = '0; rs2_reg_val = '0;
      rd_addr = '0; unit_result = '0; unit_done = 1'b0; wb_ready = 1'b0;
      @(posedge clk);
      #1;
      // Reset: every output zero, op_ready held low while rst is high.
      e = '0; e.chk_unit = 1'b1; e.chk_wb = 1'b1;
      busy(1'b0, 16'($urandom), 1'b1, e);
      busy(1'b1, 16'($urandom), 1'b1, e);
      rst = 1'b0;
      idle_cycles(2);

      // Add with a stray unit_done during EXEC.
      snap();
      run_op(4'd0, 16'h0005, 16'h0003, 4'd2, 16'h0008, 0, 0, 1'b1);
      idle_cycles(2);
      check_lit("add_wb_latency", wb_lat, 2);
      check_lit("add_wb_data", wb_data_seen, 16'h0008);
      check_lit("add_wb_rd", wb_rd_seen, 2);
      check_lit("add_sel_cycles", sel_cnt - b_sel, 1);

      // Back-to-back single-cycle ops.
      for (int i = 0; i < 4; i++) begin
         case (q_op[i])
            4'd1:    r = q_a[i] - q_b[i];
            4'd4:    r = q_a[i] & q_b[i];
            4'd5:    r = q_a[i] | q_b[i];
            default: r = q_a[i] ^ q_b[i];
         endcase
         run_op(q_op[i], q_a[i], q_b[i], 4'(i + 3), r, 0, 0, 1'b0);
      end
      check_lit("xor_wb_data", wb_data_seen, 16'h5555);
      idle_cycles(1);

      // Mul: done on the 4th MC_WAIT cycle, stray done during MC_START.
      snap();
      run_op(4'd2, 16'd9, 16'd11, 4'd8, 16'h0063, 3, 0, 1'b1);
      idle_cycles(2);
      check_lit("mul_wb_latency", wb_lat, 6);
      check_lit("mul_wb_data", wb_data_seen, 16'h0063);
      check_lit("mul_start_pulses", start_cnt - b_start, 1);
      check_lit("mul_sel_cycles", sel_cnt - b_sel, 5);

      // Div with immediate done.
      run_op(4'd3, 16'd100, 16'd7, 4'd9, 16'd14, 0, 0, 1'b0);
      idle_cycles(2);
      check_lit("div_wb_latency", wb_lat, 3);

      // Div by zero.
      snap();
      run_op(4'd3, 16'h1234, 16'h0000, 4'd10, 16'h0000, 0, 0, 1'b0);
      idle_cycles(2);
      check_lit("div0_wb_latency", wb_lat, 1);
      check_lit("div0_wb_data", wb_data_seen, 16'hFFFF);
      check_lit("div0_start_pulses", start_cnt - b_start, 0);
      check_lit("div0_sel_cycles", sel_cnt - b_sel, 0);

      // Illegal opcodes 9, 7 (first illegal) and 15.
      snap();
      run_op(4'd9, 16'h1111, 16'h2222, 4'd1, 16'h0, 0, 0, 1'b0);
      idle_cycles(2);
      check_lit("illegal_ready_back", rdy_lat, 2);
      run_op(4'd7, 16'h3333, 16'h4444, 4'd1, 16'h0, 0, 0, 1'b0);
      run_op(4'd15, 16'h5555, 16'h6666, 4'd1, 16'h0, 0, 0, 1'b0);
      idle_cycles(1);
      check_lit("illegal_pulses", erri_cnt - b_erri, 3);
      check_lit("illegal_no_wb", wbv_cnt - b_wbv, 0);

      // Timeout: done never arrives.
      snap();
      run_op(4'd3, 16'd50, 16'd2, 4'd11, 16'h0, TIMEOUT, 0, 1'b0);
      idle_cycles(2);
      check_lit("timeout_latency", errt_lat, TIMEOUT + 2);
      check_lit("timeout_pulses", errt_cnt - b_errt, 1);
      check_lit("timeout_no_wb", wbv_cnt - b_wbv, 0);

      // Done coincident with the last count wins.
      snap();
      run_op(4'd3, 16'd50, 16'd2, 4'd12, 16'd25, TIMEOUT - 1, 0, 1'b0);
      idle_cycles(2);
      check_lit("late_done_latency", wb_lat, TIMEOUT + 2);
      check_lit("late_done_no_err", errt_cnt - b_errt, 0);
      check_lit("late_done_data", wb_data_seen, 16'd25);

      // Backpressure: wb_ready low for 5 cycles.
      snap();
      run_op(4'd6, 16'h0F0F, 16'h00FF, 4'd13, 16'h0FF0, 0, 5, 1'b0);
      idle_cycles(2);
      check_lit("bp_wb_cycles", wbv_cnt - b_wbv, 6);

      // Reset while in MC_WAIT, with done raised in the reset cycle.
      snap();
      take_idle(e);
      drive(1'b1, 4'd2, 16'h1234, 16'h0042, 4'd7, 1'b0, 16'h0, 1'b1, e);
      e = '0; e.sel = 7'b0000100; e.start = 1'b1; e.chk_unit = 1'b1;
      e.rs1 = 16'h1234; e.rs2 = 16'h0042;
      busy(1'b0, 16'($urandom), 1'b1, e);
      e.start = 1'b0;
      busy(1'b0, 16'($urandom), 1'b1, e);
      busy(1'b0, 16'($urandom), 1'b1, e);
      rst = 1'b1;
      busy(1'b1, 16'hBEEF, 1'b1, e);
      e = '0; e.chk_unit = 1'b1; e.chk_wb = 1'b1;
      busy(1'b0, 16'($urandom), 1'b1, e);
      rst = 1'b0;
      idle_cycles(3);
      check_lit("rst_no_wb", wbv_cnt - b_wbv, 0);
      check_lit("rst_no_err", (errt_cnt - b_errt) + (erri_cnt - b_erri), 0);

      // Recovery after reset.
      run_op(4'd0, 16'h7000, 16'h0FFF, 4'd14, 16'h7FFF, 0, 1, 1'b0);
      idle_cycles(2);
      check_lit("recover_wb_data", wb_data_seen, 16'h7FFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage issue controller for the 16-bit CPU.
- Accepts one decoded operation at a time and drives the opcode-indexed unit select and registered operands into the functional units (add, sub, mul, div, and, or, xor).
- Sequences single-cycle and multi-cycle (mul/div) units and presents the result on a valid/ready writeback port.
- Flags illegal opcodes and multi-cycle timeouts.

Parameters:
- N, 16, datapath width.
- SEL_LINE, 4, opcode width.
- TIMEOUT, 32, maximum cycles to wait in MC_WAIT for unit_done before aborting.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active high.
- op_valid  in  1  operation offered.
- op_ready  out  1  controller can accept; high only in IDLE and rst low.
- op_opcode  in  SEL_LINE  0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor; 7..15 illegal.
- rs1_reg_val  in  N  operand 1.
- rs2_reg_val  in  N  operand 2.
- rd_addr  in  4  destination register.
- unit_sel  out  7  one-hot unit select; bit i = opcode i.
- unit_rs1  out  N  registered operand 1 to units.
- unit_rs2  out  N  registered operand 2 to units.
- unit_start  out  1  one-cycle start pulse, mul/div only.
- unit_result  in  N  result of the unit selected by unit_sel.
- unit_done  in  1  multi-cycle unit finished; unit_result valid this cycle.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  writeback accepted.
- wb_rd  out  4  destination register.
- wb_data  out  N  result.
- err_illegal  out  1  one-cycle pulse on an illegal opcode.
- err_timeout  out  1  one-cycle pulse on a multi-cycle timeout.

Behaviour:
- States: IDLE, EXEC, MC_START, MC_WAIT, WB, ERR.
- Reset:
  - state IDLE.
  - unit_sel, unit_rs1, unit_rs2, unit_start, wb_valid, wb_rd, wb_data, err_illegal, err_timeout all 0.
  - Timeout counter 0.
  - op_ready 0 while rst is high.
- Reset mid-operation abandons the operation; no writeback and no error pulse is produced.
- IDLE:
  - op_ready=1.
  - On op_valid, capture opcode, rs1, rs2, rd into registers.
  - Next state by opcode:
    - 0,1,4,5,6 -> EXEC.
    - 2 -> MC_START.
    - 3 with rs2!=0 -> MC_START.
    - 3 with rs2==0 -> WB with wb_data = all ones; no unit_sel, no unit_start.
    - >6 -> ERR.
- EXEC:
  - One cycle; unit_sel = one-hot of the opcode; unit_rs1/unit_rs2 = captured operands.
  - unit_result is registered into wb_data at the end of the cycle -> WB.
  - unit_done is ignored in EXEC.
- MC_START:
  - unit_sel asserted, unit_start=1 for exactly this cycle; counter cleared -> MC_WAIT.
  - unit_done in this cycle is ignored.
- MC_WAIT:
  - unit_sel held, unit_start=0, counter increments each cycle.
  - On unit_done, register unit_result into wb_data -> WB.
  - Else, when counter reaches TIMEOUT-1, err_timeout pulses for the next cycle -> IDLE with no writeback.
  - unit_done in the same cycle as the timeout limit wins: normal writeback, no error.
- WB:
  - unit_sel=0.
  - wb_valid=1; wb_rd and wb_data stable while wb_ready is low.
  - wb_valid && wb_ready -> IDLE next cycle, wb_valid=0.
- ERR:
  - One cycle, err_illegal=1, no writeback -> IDLE.
- Latency, single-cycle op: accepted at edge T, EXEC in cycle T+1, wb_valid high from cycle T+2.
- Latency, mul/div: 3 cycles plus unit latency to wb_valid.
- Throughput: one operation in flight; op_ready=0 outside IDLE.
- Operands are not re-sampled after acceptance; changes on rs1_reg_val/rs2_reg_val are ignored until the next IDLE accept.

Test Plan:
- Add: op_valid, opcode 0, rs1=0x0005, rs2=0x0003, rd=2; unit returns 0x0008 -> unit_sel=7'b0000001 for one cycle; wb_valid two cycles after accept with wb_rd=2, wb_data=0x0008.
- Mul with done after 4 cycles: opcode 2, unit_result=0x0063 -> unit_start single pulse, unit_sel=7'b0000100 held until done; wb_data=0x0063.
- Div by zero: opcode 3, rs2=0 -> no unit_start, unit_sel stays 0; wb_data=0xFFFF.
- Illegal opcode 9 -> err_illegal one-cycle pulse, no wb_valid; op_ready back high 2 cycles after accept.
- Timeout: opcode 3, rs2=2, unit_done never asserted -> err_timeout pulse after TIMEOUT cycles in MC_WAIT, no writeback.
- Variant: unit_done coincident with the last count -> normal writeback.
- Backpressure and reset:
  - wb_ready low for 5 cycles -> wb_valid, wb_rd, wb_data stable; op_ready=0 throughout.
  - rst asserted in MC_WAIT -> next cycle all outputs 0, state IDLE, no writeback.
